fifo_wr_arbiter: RTL

Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of the `fifo` block. Each producer presents a word with a level request; the arbiter grants one owner at a time for a bounded burst, drives `fifo`'s `wr`/`data_in`, and honours `full` as backpressure. It sits between the producer agents and `fifo`, on the same `clock`/`rst` domain.

---
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ level-request producers, bounded bursts.
// Latency: one cycle from req to first gnt; one IDLE cycle per handover. Backpressure: fifo_full stalls the owner combinationally.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]   owner_inc;
    logic [ID_W-1:0]   pick_id, cand;
    logic              pick_vld;
    logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
    logic              owner_req;
    logic              accept;
    int                idx;

    // Scan downwards so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    assign owner_inc = (owner_id == ID_W'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;
    assign owner_req = req[owner_id];
    assign accept    = (state == OWN) && owner_req && !fifo_full;
    assign busy      = (state == OWN);

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner_id;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        gnt           = '0;
        fifo_wr       = accept;
        fifo_data     = '0;

        if (accept) gnt[owner_id] = 1'b1;
        if (state == OWN) fifo_data = req_data[int'(owner_id)*DATA_WIDTH +: DATA_WIDTH];

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt     = OWN;
                    owner_nxt     = pick_id;
                    burst_cnt_nxt = '0;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner_inc;
                end else if (!fifo_full) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt_nxt == CNT_W'(MAX_BURST)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = owner_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner_id  <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule
